// File: rtl/mem_arbiter.sv
// Shares one asynchronous-read SRAM port between the RISC5 core and a single
// DMA requester. DMA is granted bounded bursts; the core is stalled via stallX.
module mem_arbiter #(
    parameter int MEM_AW = 18,
    parameter int BURST  = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       cpu_adr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_ben,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stallX,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_urgent,
    input  logic [MEM_AW-1:0] dma_adr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_ack,
    output logic [31:0]       dma_rdata,
    output logic [MEM_AW-1:0] mem_adr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic              mem_oe
);

    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} own_e;

    own_e       own_q, own_d;
    logic [7:0] gcnt_q, gcnt_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       io;
    logic       we_raw;
    logic       unused_cpu_rd;

    // Reads always drive all lanes, so the read strobe itself carries no information here.
    assign unused_cpu_rd = cpu_rd;

    assign io = &cpu_adr[23:6];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_q  <= OWN_CPU;
            gcnt_q <= 8'd0;
            bcnt_q <= 8'd0;
        end else begin
            own_q  <= own_d;
            gcnt_q <= gcnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    always_comb begin
        own_d  = own_q;
        gcnt_d = gcnt_q;
        bcnt_d = bcnt_q;
        case (own_q)
            OWN_CPU: begin
                if (gcnt_q != 8'd0) gcnt_d = gcnt_q - 8'd1;
                // Grant on the edge that ends the last gap cycle, so GAP CPU cycles separate bursts.
                if (dma_req && (gcnt_d == 8'd0 || dma_urgent)) begin
                    own_d  = OWN_DMA;
                    bcnt_d = 8'(BURST - 1);
                end
            end
            OWN_DMA: begin
                if (!dma_req || bcnt_q == 8'd0) begin
                    own_d  = OWN_CPU;
                    gcnt_d = 8'(GAP);
                end else begin
                    bcnt_d = bcnt_q - 8'd1;
                end
            end
            default: own_d = OWN_CPU;
        endcase
    end

    always_comb begin
        mem_adr   = cpu_adr[MEM_AW+1:2];
        mem_wdata = cpu_wdata;
        we_raw    = cpu_wr & ~io;
        mem_be    = 4'b1111;
        dma_ack   = 1'b0;
        if (own_q == OWN_DMA) begin
            // Any stray CPU strobe is ignored while DMA owns the bus.
            mem_adr   = dma_adr;
            mem_wdata = dma_wdata;
            we_raw    = dma_req & dma_we;
            dma_ack   = dma_req & rst;
        end else if (cpu_wr && cpu_ben) begin
            mem_be = 4'b0001 << cpu_adr[1:0];
        end
        if (!rst) mem_be = 4'b1111;
    end

    // Gating with rst makes a reset abort the current write at once.
    assign mem_we    = we_raw & rst;
    assign mem_oe    = ~mem_we;
    assign stallX    = (own_q == OWN_DMA);
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: CPU pass-through, burst/gap timing, urgent
// bypass, I/O write masking and asynchronous reset mid-burst.
module tb_mem_arbiter;

    localparam int MEM_AW = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic [23:0]       cpu_adr;
    logic              cpu_rd, cpu_wr, cpu_ben;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              stallX;
    logic              dma_req, dma_we, dma_urgent;
    logic [MEM_AW-1:0] dma_adr;
    logic [31:0]       dma_wdata;
    logic              dma_ack;
    logic [31:0]       dma_rdata;
    logic [MEM_AW-1:0] mem_adr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic              mem_oe;

    int n_chk  = 0;
    int n_fail = 0;
    int n;
    logic run;

    mem_arbiter #(.MEM_AW(MEM_AW), .BURST(8), .GAP(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_ben(cpu_ben),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stallX(stallX),
        .dma_req(dma_req), .dma_we(dma_we), .dma_urgent(dma_urgent),
        .dma_adr(dma_adr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_be(mem_be), .mem_oe(mem_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles starting from one already observed; ends on the first non-stall cycle.
    task automatic burst_len(output int len);
        len = 1;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (run) begin
                tick();
                #1;
                if (stallX === 1'b1) len++;
                else run = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        cpu_adr = 24'h000105; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_ben = 1'b1;
        cpu_wdata = 32'h0000AB00;
        dma_req = 1'b1; dma_we = 1'b1; dma_urgent = 1'b0;
        dma_adr = 18'h2AAAA; dma_wdata = 32'hDEADBEEF;
        mem_rdata = 32'h12345678;

        #3;
        chk("rst_stall", stallX, 1'b0);
        chk("rst_ack", dma_ack, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_be", mem_be, 4'b1111);
        #4;
        chk("rst_stall_after_edge", stallX, 1'b0);
        dma_req = 1'b0;
        #4 rst = 1'b1;

        // CPU byte write
        tick(); #1;
        chk("byte_adr", mem_adr, 18'h41);
        chk("byte_be", mem_be, 4'b0010);
        chk("byte_we", mem_we, 1'b1);
        chk("byte_wdata", mem_wdata, 32'h0000AB00);
        chk("byte_stall", stallX, 1'b0);
        chk("byte_oe", mem_oe, 1'b0);
        chk("cpu_rdata", cpu_rdata, 32'h12345678);
        chk("dma_rdata", dma_rdata, 32'h12345678);

        // Word write, then read
        tick(); cpu_ben = 1'b0; cpu_adr = 24'h000107; #1;
        chk("word_be", mem_be, 4'b1111);
        chk("word_we", mem_we, 1'b1);
        tick(); cpu_wr = 1'b0; cpu_rd = 1'b1; #1;
        chk("rd_we", mem_we, 1'b0);
        chk("rd_oe", mem_oe, 1'b1);

        // I/O-space write never reaches SRAM
        tick(); cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_adr = 24'hFFFFC4; #1;
        chk("io_we", mem_we, 1'b0);
        chk("io_adr", mem_adr, 18'h3FFF1);
        tick(); cpu_wr = 1'b0; cpu_adr = 24'h000000; #1;

        // Full burst with GAP
        tick(); dma_req = 1'b1; dma_we = 1'b1; #1;
        chk("b_c0_stall", stallX, 1'b0);
        chk("b_c0_ack", dma_ack, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) begin
                cpu_wr = 1'b1; cpu_ben = 1'b1; cpu_adr = 24'h000105;
            end
            #1;
            chk("b_stall", stallX, 1'b1);
            chk("b_ack", dma_ack, 1'b1);
            if (i == 2) begin
                chk("b_mux_adr", mem_adr, 18'h2AAAA);
                chk("b_mux_wdata", mem_wdata, 32'hDEADBEEF);
                chk("b_mux_we", mem_we, 1'b1);
                chk("b_mux_be", mem_be, 4'b1111);
                cpu_wr = 1'b0; cpu_ben = 1'b0; cpu_adr = 24'h000000;
            end
        end
        tick(); #1;
        chk("gap_c9_stall", stallX, 1'b0);
        chk("gap_c9_ack", dma_ack, 1'b0);
        tick(); #1;
        chk("gap_c10_stall", stallX, 1'b0);
        tick(); #1;
        chk("regrant_c11_stall", stallX, 1'b1);
        chk("regrant_c11_ack", dma_ack, 1'b1);
        dma_req = 1'b0; #1;
        chk("ack_follows_req", dma_ack, 1'b0);
        tick(); tick(); tick();

        // Early drop after third ack, immediate re-raise
        tick(); dma_req = 1'b1; dma_we = 1'b0; #1;
        chk("e_c0_stall", stallX, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            chk("e_stall", stallX, 1'b1);
            chk("e_ack", dma_ack, 1'b1);
            chk("e_rd_we", mem_we, 1'b0);
        end
        tick(); dma_req = 1'b0; #1;
        chk("e_c4_stall", stallX, 1'b1);
        chk("e_c4_ack", dma_ack, 1'b0);
        tick(); dma_req = 1'b1; #1;
        chk("e_c5_stall", stallX, 1'b0);
        chk("e_c5_ack", dma_ack, 1'b0);
        tick(); #1;
        chk("e_c6_stall", stallX, 1'b0);
        tick(); #1;
        chk("e_c7_stall", stallX, 1'b1);

        // Urgent: exactly one CPU cycle between bursts
        dma_urgent = 1'b1;
        burst_len(n);
        chk("u_burst_len", n, 8);
        chk("u_gap_ack", dma_ack, 1'b0);
        tick(); #1;
        chk("u_regrant_stall", stallX, 1'b1);
        chk("u_regrant_ack", dma_ack, 1'b1);
        dma_req = 1'b0; dma_urgent = 1'b0;
        tick(); tick(); tick();

        // Reset in beat 4
        tick(); dma_req = 1'b1; dma_we = 1'b1; #1;
        for (int i = 1; i <= 4; i++) begin
            tick(); #1;
            chk("r_stall", stallX, 1'b1);
        end
        chk("r_we_before", mem_we, 1'b1);
        rst = 1'b0; #1;
        chk("r_stall_async", stallX, 1'b0);
        chk("r_ack_async", dma_ack, 1'b0);
        chk("r_we_async", mem_we, 1'b0);
        chk("r_be_async", mem_be, 4'b1111);
        tick(); #1;
        chk("r_stall_held", stallX, 1'b0);
        rst = 1'b1; #1;
        chk("r_rel_stall", stallX, 1'b0);
        tick(); #1;
        chk("r_grant_stall", stallX, 1'b1);
        chk("r_grant_ack", dma_ack, 1'b1);
        burst_len(n);
        chk("r_burst_len", n, 8);
        dma_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
